key_matrix_scan: RTL and testbench
==================================

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 SHALL have parameter CLK_REF, default 48_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter CLK_SCAN, default 1_000_000, column step rate in Hz; CLK_REF/CLK_SCAN is an integer of at least 16.
REQ-003 SHALL have parameter DEB_SCANS, default 4, number of consecutive identical frames a column must hold before a change commits (range 2..15).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port btnCpuReset, input, 1, reset: asynchronous assert, active-low.
REQ-006 SHALL have port COLUMN, output, 8, active-low one-hot column drive to the 8x8 key matrix.
REQ-007 SHALL have port STRING, input, 8, active-low row returns, asynchronous to clk; bit r low means the key at (driven column, r) is pressed.
REQ-008 SHALL have port key_code, output, 6, event key index {col[2:0], row[2:0]}.
REQ-009 SHALL have port key_press, output, 1, event type: 1 = press, 0 = release.
REQ-010 SHALL have port key_valid, output, 1, event available.
REQ-011 SHALL have port key_ready, input, 1, consumer accepts the event.
REQ-012 SHALL have port ovf, output, 1, sticky flag: an event was dropped.

Function
REQ-013 STRING SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A prescaler SHALL count 0..CLK_REF/CLK_SCAN-1 and issue a one-cycle tick at the terminal count.
REQ-015 On each tick, the block SHALL sample the synchronized STRING for the current column, then advance the column index modulo 8 (7 wraps to 0). One frame is 8 ticks.
REQ-016 COLUMN SHALL equal ~(8'h01 << col) at all times; exactly one bit is low.
REQ-017 Per column, the block SHALL hold the last raw sample, the committed stable row vector, and a 4-bit saturating match counter.
REQ-018 A sample equal to the last raw sample SHALL increment the counter; a differing sample SHALL clear it to 0 and replace the last raw sample.
REQ-019 When the counter reaches DEB_SCANS-1 and raw differs from stable, the block SHALL commit raw to stable and enter state EMIT.
REQ-020 The FSM SHALL have states SCAN and EMIT. EMIT walks rows 0..7, one row per clock (8 clocks), pushing one event per changed bit, lowest row first, then returns to SCAN.
REQ-021 The prescaler and column drive SHALL keep running during EMIT. A commit cannot recur within 8 clocks because ticks are at least 16 clocks apart.
REQ-022 Output handshake: an event transfers on a clock with key_valid=1 and key_ready=1. key_code and key_press SHALL hold stable while key_valid=1 and key_ready=0.
REQ-023 A push into a full buffer SHALL drop the new event and set ovf.
REQ-024 A push and a pop in the same cycle on a full buffer SHALL succeed without loss.
REQ-025 ovf SHALL clear only on reset.
REQ-026 Two keys changing in the same column and frame SHALL produce two events. Keys in different columns SHALL produce events in column scan order.

Reset
REQ-027 While btnCpuReset=0, the block SHALL hold COLUMN=8'hFE, key_valid=0, key_code=0, key_press=0 and ovf=0. All stable vectors are released, raw samples are 8'hFF, counters and prescaler are 0, the synchronizer is 8'hFF, and the FSM is in SCAN.
REQ-028 Reset asserted mid-EMIT SHALL discard all pending and buffered events.

Configuration
REQ-029 With macro KEY_FIFO_EN defined, the output buffer SHALL be a 4-entry FIFO, and key_valid SHALL be high whenever the FIFO is non-empty.
REQ-030 Without KEY_FIFO_EN, the output buffer SHALL be a single register, and any push while key_valid=1 and key_ready=0 is dropped with ovf set.

Verification
REQ-031 Hold STRING[5] low whenever COLUMN[2] is low for 6 frames, with key_ready=1 -> exactly one event: key_code=6'h15, key_press=1.
REQ-032 Pulse the same key for 2 frames only (less than DEB_SCANS) -> no event, ovf=0.
REQ-033 Release a held key 6'h15 -> exactly one event: key_code=6'h15, key_press=0.
REQ-034 Press rows 1 and 6 of column 3 together -> events 6'h19 then 6'h1E, both with key_press=1, in consecutive accepted transfers.
REQ-035 key_ready=0 while 5 presses commit, with KEY_FIFO_EN -> 4 events retained in order, ovf=1. Without KEY_FIFO_EN -> first event retained, ovf=1.
REQ-036 Assert btnCpuReset during EMIT -> next cycle key_valid=0, COLUMN=8'hFE, ovf=0.

Source files
------------

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 8x8 key matrix scanner with per-column debounce and press/release event output.
// Define KEY_FIFO_EN for a 4-entry event FIFO; otherwise a single output register is used.
module key_matrix_scan #(
  parameter int CLK_REF   = 48_000_000,
  parameter int CLK_SCAN  = 1_000_000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       btnCpuReset,
  output logic [7:0] COLUMN,
  input  logic [7:0] STRING,
  output logic [5:0] key_code,
  output logic       key_press,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       ovf
);
  localparam int DIV = CLK_REF / CLK_SCAN;
  localparam int PW  = $clog2(DIV);
  typedef enum logic {SCAN, EMIT} state_t;
  state_t r_state, w_next;
  logic [7:0] r_sync1, r_sync2;
  logic [PW-1:0] r_presc;
  logic [2:0] r_col, r_ecol, r_row;
  logic [7:0] r_raw [8];
  logic [7:0] r_stable [8];
  logic [3:0] r_cnt [8];
  logic [7:0] r_diff, r_new;
  logic [3:0] w_cnt_inc;
  logic w_tick, w_match, w_commit, w_push, w_press;
  logic [5:0] w_code;
  logic r_ovf;
  assign COLUMN = ~(8'h01 << r_col);
  assign ovf = r_ovf;
  always_comb begin
    w_tick    = r_presc == PW'(DIV - 1);
    w_match   = r_sync2 == r_raw[r_col];
    w_cnt_inc = r_cnt[r_col] == 4'hF ? 4'hF : r_cnt[r_col] + 4'd1;
    w_commit  = r_state == SCAN && w_tick && w_match && w_cnt_inc >= 4'(DEB_SCANS - 1)
                && r_raw[r_col] != r_stable[r_col];
    w_push    = r_state == EMIT && r_diff[r_row];
    w_code    = {r_ecol, r_row};
    w_press   = ~r_new[r_row];
    w_next    = r_state == SCAN ? (w_commit ? EMIT : SCAN) : (r_row == 3'd7 ? SCAN : EMIT);
  end
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
      r_presc <= '0;
      r_col   <= 3'd0;
      r_state <= SCAN;
      r_row   <= 3'd0;
      r_ecol  <= 3'd0;
      r_diff  <= 8'h00;
      r_new   <= 8'hFF;
      for (int i = 0; i < 8; i++) begin
        r_raw[i]    <= 8'hFF;
        r_stable[i] <= 8'hFF;
        r_cnt[i]    <= 4'd0;
      end
    end else begin
      r_sync1 <= STRING;
      r_sync2 <= r_sync1;
      r_state <= w_next;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_row   <= r_state == EMIT ? r_row + 3'd1 : 3'd0;
      if (w_tick) begin
        r_col <= r_col + 3'd1;
        if (w_match) r_cnt[r_col] <= w_cnt_inc;
        else begin
          r_cnt[r_col] <= 4'd0;
          r_raw[r_col] <= r_sync2;
        end
      end
      if (w_commit) begin
        r_stable[r_col] <= r_raw[r_col];
        r_diff <= r_raw[r_col] ^ r_stable[r_col];
        r_new  <= r_raw[r_col];
        r_ecol <= r_col;
      end
    end
  end
`ifdef KEY_FIFO_EN
  logic [6:0] r_mem [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_fcnt;
  logic w_pop, w_acc;
  assign w_pop = key_valid && key_ready;
  assign w_acc = w_push && (r_fcnt != 3'd4 || w_pop);
  assign key_valid = r_fcnt != 3'd0;
  assign {key_press, key_code} = r_mem[r_rp];
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 7'd0;
      r_wp   <= 2'd0;
      r_rp   <= 2'd0;
      r_fcnt <= 3'd0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_mem[r_wp] <= {w_press, w_code};
        r_wp <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_fcnt <= r_fcnt + 3'(w_acc) - 3'(w_pop);
      if (w_push && !w_acc) r_ovf <= 1'b1;
    end
  end
`else
  logic r_valid, r_press;
  logic [5:0] r_code;
  assign key_valid = r_valid;
  assign key_press = r_press;
  assign key_code  = r_code;
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      r_valid <= 1'b0;
      r_press <= 1'b0;
      r_code  <= 6'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push && (!r_valid || key_ready)) begin
        r_valid <= 1'b1;
        r_press <= w_press;
        r_code  <= w_code;
      end else if (key_ready) r_valid <= 1'b0;
      if (w_push && r_valid && !key_ready) r_ovf <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: randomized key-matrix bench with an event-level reference model.
module tb_key_matrix_scan;
  localparam int FR = 128;
  logic clk = 1'b0;
  logic btnCpuReset = 1'b0;
  logic [7:0] COLUMN, STRING;
  logic [5:0] key_code;
  logic key_press, key_valid, key_ready = 1'b1, ovf;
  logic [7:0] keys [8];
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic p; logic [5:0] c;} ev_t;
  ev_t q[$];

  key_matrix_scan #(.CLK_REF(16), .CLK_SCAN(1), .DEB_SCANS(4)) dut (
    .clk(clk), .btnCpuReset(btnCpuReset), .COLUMN(COLUMN), .STRING(STRING),
    .key_code(key_code), .key_press(key_press), .key_valid(key_valid),
    .key_ready(key_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    STRING = 8'hFF;
    for (int c = 0; c < 8; c++) if (!COLUMN[c]) STRING = STRING & ~keys[c];
  end

  always @(negedge clk) if (btnCpuReset && key_valid && key_ready) q.push_back({key_press, key_code});

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_col0();
    int k = 0;
    while (COLUMN !== 8'hFE && k < 200) begin step(1); k++; end
    n_cmp++;
    if (COLUMN !== 8'hFE) begin n_bad++; $display("FAIL col0_wait got %h want fe", COLUMN); end
  endtask

  task automatic test_reset();
    btnCpuReset = 1'b0;
    step(3);
    n_cmp++; if (COLUMN !== 8'hFE) begin n_bad++; $display("FAIL rst_column got %h want fe", COLUMN); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", key_valid); end
    n_cmp++; if (key_code !== 6'd0) begin n_bad++; $display("FAIL rst_code got %h want 00", key_code); end
    n_cmp++; if (key_press !== 1'b0) begin n_bad++; $display("FAIL rst_press got %b want 0", key_press); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", ovf); end
    btnCpuReset = 1'b1;
    step(2);
  endtask

  task automatic test_press();
    q.delete();
    keys[2][5] = 1'b1;
    step(6 * FR);
    n_cmp++; if (q.size() !== 1) begin n_bad++; $display("FAIL press_count got %0d want 1", q.size()); end
    if (q.size() > 0) begin
      n_cmp++; if (q[0].c !== 6'h15) begin n_bad++; $display("FAIL press_code got %h want 15", q[0].c); end
      n_cmp++; if (q[0].p !== 1'b1) begin n_bad++; $display("FAIL press_type got %b want 1", q[0].p); end
    end
  endtask

  task automatic test_release();
    q.delete();
    keys[2][5] = 1'b0;
    step(6 * FR);
    n_cmp++; if (q.size() !== 1) begin n_bad++; $display("FAIL release_count got %0d want 1", q.size()); end
    if (q.size() > 0) begin
      n_cmp++; if (q[0].c !== 6'h15) begin n_bad++; $display("FAIL release_code got %h want 15", q[0].c); end
      n_cmp++; if (q[0].p !== 1'b0) begin n_bad++; $display("FAIL release_type got %b want 0", q[0].p); end
    end
  endtask

  task automatic test_pulse();
    q.delete();
    keys[2][5] = 1'b1;
    step(2 * FR);
    keys[2][5] = 1'b0;
    step(6 * FR);
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL pulse_count got %0d want 0", q.size()); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL pulse_ovf got %b want 0", ovf); end
  endtask

  task automatic test_two_keys();
    q.delete();
    keys[3] = 8'h42;
    step(6 * FR);
    n_cmp++; if (q.size() !== 2) begin n_bad++; $display("FAIL two_count got %0d want 2", q.size()); end
    if (q.size() > 1) begin
      n_cmp++; if (q[0] !== {1'b1, 6'h19}) begin n_bad++; $display("FAIL two_first got %h want 59", q[0]); end
      n_cmp++; if (q[1] !== {1'b1, 6'h1E}) begin n_bad++; $display("FAIL two_second got %h want 5e", q[1]); end
    end
    keys[3] = 8'h00;
    step(6 * FR);
    q.delete();
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int c;
      logic [7:0] m;
      ev_t exp_q[$];
      c = int'($urandom_range(0, 7));
      m = 8'($urandom_range(1, 255));
      keys[c] = keys[c] ^ m;
      q.delete();
      step(6 * FR);
      for (int r = 0; r < 8; r++) if (m[r]) exp_q.push_back({keys[c][r], 3'(c), 3'(r)});
      n_cmp++;
      if (q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count it %0d got %0d want %0d", it, q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_event it %0d idx %0d got %h want %h", it, i, q[i], exp_q[i]); end
      end
    end
    for (int c = 0; c < 8; c++) keys[c] = 8'h00;
    step(6 * FR);
    q.delete();
  endtask

  task automatic test_scan_order();
    wait_col0();
    q.delete();
    keys[5] = 8'h01;
    keys[2] = 8'h80;
    step(6 * FR);
    n_cmp++; if (q.size() !== 2) begin n_bad++; $display("FAIL order_count got %0d want 2", q.size()); end
    if (q.size() > 1) begin
      n_cmp++; if (q[0] !== {1'b1, 6'h17}) begin n_bad++; $display("FAIL order_first got %h want 57", q[0]); end
      n_cmp++; if (q[1] !== {1'b1, 6'h28}) begin n_bad++; $display("FAIL order_second got %h want 68", q[1]); end
    end
    keys[5] = 8'h00;
    keys[2] = 8'h00;
    step(6 * FR);
    q.delete();
  endtask

  task automatic test_overflow();
    int keep;
    ev_t exp_q[$];
`ifdef KEY_FIFO_EN
    keep = 4;
`else
    keep = 1;
`endif
    key_ready = 1'b0;
    wait_col0();
    q.delete();
    for (int c = 1; c <= 5; c++) keys[c] = 8'h04;
    step(6 * FR);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", ovf); end
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got %b want 1", key_valid); end
    for (int c = 1; c <= keep; c++) exp_q.push_back({1'b1, 3'(c), 3'd2});
    key_ready = 1'b1;
    step(20);
    n_cmp++;
    if (q.size() !== exp_q.size()) begin n_bad++; $display("FAIL ovf_count got %0d want %0d", q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (q[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_event idx %0d got %h want %h", i, q[i], exp_q[i]); end
    end
    for (int c = 1; c <= 5; c++) keys[c] = 8'h00;
    step(6 * FR);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    q.delete();
  endtask

  task automatic test_reset_emit();
    int k = 0;
    keys[6] = 8'h81;
    while (key_valid !== 1'b1 && k < 8 * FR) begin step(1); k++; end
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL emit_wait got %b want 1", key_valid); end
    btnCpuReset = 1'b0;
    keys[6] = 8'h00;
    step(1);
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL emitrst_valid got %b want 0", key_valid); end
    n_cmp++; if (COLUMN !== 8'hFE) begin n_bad++; $display("FAIL emitrst_column got %h want fe", COLUMN); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL emitrst_ovf got %b want 0", ovf); end
    n_cmp++; if (key_code !== 6'd0) begin n_bad++; $display("FAIL emitrst_code got %h want 00", key_code); end
    btnCpuReset = 1'b1;
    q.delete();
    step(6 * FR);
    n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL emitrst_discard got %0d want 0", q.size()); end
  endtask

  initial begin
    for (int c = 0; c < 8; c++) keys[c] = 8'h00;
    test_reset();
    test_press();
    test_release();
    test_pulse();
    test_two_keys();
    test_random();
    test_scan_order();
    test_overflow();
    test_reset_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
